// File: rtl/program_loader.sv
// Boot-time byte-stream loader: assembles little-endian words, writes MIPS2 program memory,
// and holds the CPU in reset until the load completes. Macro LOADER_CHECKSUM_EN adds a trailing XOR checksum word.
module program_loader #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_wr_pm,
  output logic [31:0]       o_wr_data_pm,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;
`endif

  state_t            state, state_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       low_bytes;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] last_idx;
  logic [TW-1:0]     timer;
  logic              wr_pm;
  logic [31:0]       wr_data;
  logic              last_pend;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  logic [31:0] full_word;
  logic        busy, accept, word_in, timed_out;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // A byte arriving during the final write pulse (no checksum) belongs to no load and is dropped.
  always_comb begin
    full_word = {i_rx_data, low_bytes};
    busy      = (state == LEN) || (state == DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state == CHK) busy = 1'b1;
`endif
    accept    = i_rx_valid && (busy || state == IDLE) &&
                !(state == DATA && wr_pm && last_pend);
    word_in   = accept && (byte_cnt == 2'd3);
    timed_out = busy && !i_rx_valid && (timer == TW'(TIMEOUT - 1));
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = LEN;
      LEN: begin
        if (word_in)
          state_next = (full_word == 32'd0 || full_word > 32'(DEPTH)) ? ERROR : DATA;
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (word_in && word_cnt == last_idx) state_next = CHK;
`else
        if (wr_pm && last_pend) state_next = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (word_in) state_next = (full_word == csum) ? DONE : ERROR;
`endif
      default: ;
    endcase
    if (timed_out) state_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
      word_cnt  <= '0;
      last_idx  <= '0;
      timer     <= '0;
      wr_pm     <= 1'b0;
      wr_data   <= '0;
      last_pend <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      wr_pm <= 1'b0;
      if (timed_out) begin
        byte_cnt  <= '0;
        word_cnt  <= '0;
        timer     <= '0;
        last_pend <= 1'b0;
      end else begin
        if (busy) timer <= i_rx_valid ? '0 : timer + 1'b1;
        if (accept) begin
          byte_cnt <= byte_cnt + 1'b1;
          case (byte_cnt)
            2'd0:    low_bytes[7:0]   <= i_rx_data;
            2'd1:    low_bytes[15:8]  <= i_rx_data;
            2'd2:    low_bytes[23:16] <= i_rx_data;
            default: ;
          endcase
        end
        if (word_in && state == LEN) begin
          last_idx <= full_word[ADDR_W-1:0] - 1'b1;
          word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum     <= '0;
`endif
        end
        if (word_in && state == DATA) begin
          wr_pm     <= 1'b1;
          wr_data   <= full_word;
          last_pend <= (word_cnt == last_idx);
`ifdef LOADER_CHECKSUM_EN
          csum      <= csum ^ full_word;
`endif
        end
        // Address advances only after a non-final pulse, so it stops at N-1.
        if (wr_pm && !last_pend) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  assign o_wr_pm      = wr_pm;
  assign o_wr_data_pm = wr_data;
  assign o_wr_addr    = word_cnt;
  assign o_busy       = busy;
  assign o_done       = (state == DONE);
  assign o_error      = (state == ERROR);
  assign o_cpu_reset  = (state != DONE);

endmodule
